// File: rtl/exp_fifo_drain_if.sv
// Bundle of the drain block's control, FIFO read-side and result handshake
// signals. The slave modport is the drain block itself; master is the
// surrounding logic (FIFO read port plus result consumer).
interface exp_fifo_drain_if #(
  parameter int DATA_W = 21,
  parameter int CNT_W  = 4,
  parameter int ACC_W  = DATA_W + CNT_W
);
  logic              start;
  logic [CNT_W-1:0]  n_terms;
  logic [DATA_W-1:0] fifo_q;
  logic              fifo_empty;
  logic              rd_req;
  logic [ACC_W-1:0]  sum;
  logic              sum_valid;
  logic              sum_ready;
  logic              busy;

  modport slave (
    input  start, n_terms, fifo_q, fifo_empty, sum_ready,
    output rd_req, sum, sum_valid, busy
  );

  modport master (
    output start, n_terms, fifo_q, fifo_empty, sum_ready,
    input  rd_req, sum, sum_valid, busy
  );
endinterface

// File: rtl/exp_fifo_drain.sv
// Read-side consumer of the exponential-result FIFO (non-show-ahead).
// On start it pops n_terms words, sums them into an accumulator wide enough
// that 2^CNT_W-1 maximal words cannot overflow, and offers the total on a
// valid/ready port. req_left counts reads still to issue, got_left counts
// words still to arrive; a word arrives one cycle after its rd_req.
module exp_fifo_drain #(
  parameter int DATA_W = 21,
  parameter int CNT_W  = 4,
  parameter int ACC_W  = DATA_W + CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  exp_fifo_drain_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_req_left;
  logic [CNT_W-1:0]  r_got_left;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_sum;
  logic              r_rd_pend;

  logic              w_rd_req;
  logic              w_sum_valid;
  logic              w_busy;
  logic              w_start_ok;
  logic              w_last_word;
  logic [ACC_W-1:0]  w_acc_next;

  // start is honoured only while idle; the last word is the arriving one
  // when exactly one is still outstanding.
  assign w_start_ok  = (r_state == S_IDLE) && bus.start;
  assign w_last_word = r_rd_pend && (r_got_left == CNT_W'(1));
  assign w_acc_next  = r_acc + ACC_W'(bus.fifo_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_state
    // unassigned, which would infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = (bus.n_terms == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_word) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.sum_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: reads only in RUN while data exists and reads remain;
  // independent of the downstream ready.
  always_comb begin
    w_rd_req    = 1'b0;
    w_sum_valid = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_RUN: begin
        w_busy   = 1'b1;
        w_rd_req = !bus.fifo_empty && (r_req_left != '0);
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_sum_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: counters, read-pending pipe, accumulator and result register.
  // Reset drops any word in flight by clearing rd_pend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_left <= '0;
      r_got_left <= '0;
      r_acc      <= '0;
      r_sum      <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_req;
      if (w_start_ok) begin
        r_req_left <= bus.n_terms;
        r_got_left <= bus.n_terms;
        r_acc      <= '0;
        r_sum      <= '0;
      end else begin
        if (w_rd_req) begin
          r_req_left <= r_req_left - CNT_W'(1);
        end
        if (r_rd_pend) begin
          r_acc      <= w_acc_next;
          r_got_left <= r_got_left - CNT_W'(1);
          if (w_last_word) begin
            r_sum <= w_acc_next;
          end
        end
      end
    end
  end

  assign bus.rd_req    = w_rd_req;
  assign bus.sum_valid = w_sum_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;

endmodule
